instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- IF stage of the pipelined CPU: owns the PC, drives ReadAddress into the combinational instruction memory, and captures the returned Instruction into the IF/ID pipeline register.
- Accepts stall from the hazard unit and a taken-branch redirect from EX.
- Decodes J-type jumps held in IF/ID and redirects itself.
- Flags fetches beyond the populated memory depth and converts them to bubbles.

Parameters:
- MEM_WORDS, 30, number of populated 32-bit instruction words; valid byte addresses are 0 to 4*MEM_WORDS-4.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- NOP, 32'h0000_0000, instruction value inserted for bubbles.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Stall  input  1  hazard unit: hold PC and IF/ID
- BranchTaken  input  1  EX-stage branch resolved taken
- BranchTarget  input  32  EX-stage branch target byte address
- ReadAddress  output  32  instruction memory address, equals PC
- Instruction  input  32  instruction memory read data (combinational from ReadAddress)
- IFID_Instruction  output  32  registered instruction for ID
- IFID_PCPlus4  output  32  registered PC+4 of that instruction
- IFID_Valid  output  1  IF/ID holds a real instruction, not a bubble
- JumpTaken  output  1  combinational: valid J instruction in IF/ID this cycle
- OutOfRange  output  1  combinational: PC >= 4*MEM_WORDS
- FetchCount  output  32  number of valid instructions loaded into IF/ID since reset

Behaviour:
- Reset: one clock with Reset=1 sets PC=RESET_PC, IFID_Instruction=NOP, IFID_PCPlus4=0, IFID_Valid=0, FetchCount=0. Reset overrides every other input and applies mid-stall or mid-redirect.
- ReadAddress = PC, combinational. PC[1:0] is always 00: all targets are loaded with bits [1:0] forced to 0.
- Jump decode: JumpTaken = IFID_Valid & (IFID_Instruction[31:26]==6'b000010) & !Stall. JumpTarget = {IFID_PCPlus4[31:28], IFID_Instruction[25:0], 2'b00}.
- Per-cycle priority on each rising edge: Reset > BranchTaken > Stall > JumpTaken > normal.
- BranchTaken:
  - PC <= BranchTarget & ~3.
  - IF/ID <= bubble (NOP, Valid=0).
  - Wins over a simultaneous jump in ID, because the jump is on the wrong path.
  - Wins over Stall.
- Stall, no branch: PC, IF/ID and FetchCount hold. A pending jump in IF/ID is deferred until Stall drops.
- JumpTaken: PC <= JumpTarget. IF/ID <= bubble, which squashes the sequential instruction fetched behind the jump.
- Normal:
  - PC <= PC+4, 32-bit wrap with no carry-out.
  - IFID_Instruction <= Instruction, IFID_PCPlus4 <= PC+4.
  - IFID_Valid <= !OutOfRange.
- OutOfRange fetch:
  - IFID_Instruction <= NOP and Valid=0. Instruction is ignored (memory beyond depth is undefined).
  - PC still advances by 4.
  - A later branch or jump into range resumes normal fetch.
- FetchCount increments by 1 on exactly the edges where IF/ID is loaded with Valid=1. It wraps at 2^32.
- Latency: an instruction at address A appears in IF/ID one cycle after PC==A with no stall. A redirect costs 1 bubble for a jump and 1 bubble in IF for a branch; the hazard unit flushes ID/EX separately.
- No combinational path from Stall or BranchTaken to ReadAddress. All redirects take effect on the next PC.

Decomposition:
- Shared package cpu_defs: OPCODE_J=6'b000010, NOP_INSTR=32'h0, XLEN=32, and an opcode field slice constant, reused by decode and control.
- One natural sub-module: pc_next_select, a combinational priority mux producing next PC, IF/ID load enable and bubble select from Reset, BranchTaken, Stall and JumpTaken.
- The PC register and IF/ID registers stay in the top level.

Test Plan:
- Reset then free-run 4 cycles with memory words 0..3 = 2008_0020, 2009_0027, 0109_8024, 0109_8025:
  - ReadAddress = 0, 4, 8, 12.
  - IFID_Instruction = 2008_0020 then 2009_0027, with IFID_PCPlus4 = 4 then 8.
  - FetchCount = 3 after cycle 4.
- Stall held 2 cycles at PC=8: ReadAddress stays 8 and IF/ID is unchanged. Release gives PC=12 the next edge.
- Jump word 0800_000E at address 68 enters IF/ID:
  - JumpTaken=1, next PC=0x38.
  - The following IF/ID is a bubble (Valid=0).
  - The instruction at 0x38 is in IF/ID 2 cycles after the jump.
- BranchTaken=1 with BranchTarget=0x4B while IF/ID holds the jump 0800_001F:
  - PC <= 0x48, IF/ID bubble, JumpTarget 0x7C ignored.
- Jump to 0x7C (word 31) with MEM_WORDS=30:
  - OutOfRange=1, IFID_Valid stays 0, FetchCount frozen.
  - A later branch to 0x0 resumes valid fetch.
- Reset asserted while Stall=1 and BranchTaken=1: PC=0, IFID_Valid=0, FetchCount=0 on the next edge.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared CPU definitions: opcode fields, bubble value,
// the IF/ID bundle and the next-PC source encoding.
package cpu_defs;

    localparam int XLEN = 32;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;

    localparam logic [5:0] OPCODE_J = 6'b000010;
    localparam logic [XLEN-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_BRANCH,
        SEL_HOLD,
        SEL_JUMP,
        SEL_SEQ
    } pc_sel_e;

    function automatic logic is_jump(input logic [XLEN-1:0] instr);
        return instr[OPC_HI:OPC_LO] == OPCODE_J;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: control from hazard/EX, instruction memory
// port and the IF/ID bundle presented to decode.
interface instruction_fetch_stage_if;
    import cpu_defs::*;

    logic            Stall;
    logic            BranchTaken;
    logic [XLEN-1:0] BranchTarget;
    logic [XLEN-1:0] ReadAddress;
    logic [XLEN-1:0] Instruction;
    logic [XLEN-1:0] IFID_Instruction;
    logic [XLEN-1:0] IFID_PCPlus4;
    logic            IFID_Valid;
    logic            JumpTaken;
    logic            OutOfRange;
    logic [XLEN-1:0] FetchCount;

    modport master (
        input  Stall, BranchTaken, BranchTarget, Instruction,
        output ReadAddress, IFID_Instruction, IFID_PCPlus4,
        output IFID_Valid, JumpTaken, OutOfRange, FetchCount
    );

    modport slave (
        output Stall, BranchTaken, BranchTarget, Instruction,
        input  ReadAddress, IFID_Instruction, IFID_PCPlus4,
        input  IFID_Valid, JumpTaken, OutOfRange, FetchCount
    );

endinterface

// File: rtl/instruction_fetch_stage_pc_next_select.sv
// Priority mux for the next PC: reset > branch > stall > jump
// > sequential, plus IF/ID load enable and bubble select.
module pc_next_select
    import cpu_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            reset,
    input  logic            branch_taken,
    input  logic            stall,
    input  logic            jump_taken,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] pc_next,
    output logic            ifid_load,
    output logic            ifid_bubble
);

    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

    pc_sel_e sel;

    // Pick the winning PC source by fixed priority
    always_comb begin
        sel = SEL_SEQ;
        if (reset)
            sel = SEL_RESET;
        else if (branch_taken)
            sel = SEL_BRANCH;
        else if (stall)
            sel = SEL_HOLD;
        else if (jump_taken)
            sel = SEL_JUMP;
    end

    // Translate the source into PC value and IF/ID action
    always_comb begin
        pc_next     = pc_plus4;
        ifid_load   = 1'b1;
        ifid_bubble = 1'b0;
        unique case (sel)
            SEL_RESET: begin
                pc_next     = RESET_PC & ALIGN;
                ifid_bubble = 1'b1;
            end
            SEL_BRANCH: begin
                pc_next     = branch_target & ALIGN;
                ifid_bubble = 1'b1;
            end
            SEL_HOLD: begin
                pc_next   = pc;
                ifid_load = 1'b0;
            end
            SEL_JUMP: begin
                pc_next     = jump_target & ALIGN;
                ifid_bubble = 1'b1;
            end
            SEL_SEQ: begin
                pc_next = pc_plus4;
            end
            default: begin
                pc_next = pc_plus4;
            end
        endcase
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, fetches from instruction memory,
// fills IF/ID and resolves J-type jumps sitting in IF/ID.
module instruction_fetch_stage
    import cpu_defs::*;
#(
    parameter int              MEM_WORDS = 30,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP       = NOP_INSTR
) (
    input  logic                       Clk,
    input  logic                       Reset,
    instruction_fetch_stage_if.master  bus
);

    localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(4 * MEM_WORDS);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;
    if_id_t          ifid_q, ifid_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jump_target;
    logic            out_of_range;
    logic            jump_taken;
    logic            ifid_load;
    logic            ifid_bubble;

    assign pc_plus4     = pc_q + XLEN'(4);
    assign out_of_range = pc_q >= MEM_BYTES;
    assign jump_taken   = ifid_q.valid & is_jump(ifid_q.instr)
                        & ~bus.Stall;
    assign jump_target  = {ifid_q.pc_plus4[31:28],
                           ifid_q.instr[25:0], 2'b00};

    pc_next_select #(
        .RESET_PC (RESET_PC)
    ) u_pc_next_select (
        .reset         (Reset),
        .branch_taken  (bus.BranchTaken),
        .stall         (bus.Stall),
        .jump_taken    (jump_taken),
        .pc            (pc_q),
        .pc_plus4      (pc_plus4),
        .branch_target (bus.BranchTarget),
        .jump_target   (jump_target),
        .pc_next       (pc_d),
        .ifid_load     (ifid_load),
        .ifid_bubble   (ifid_bubble)
    );

    // Next IF/ID contents and fetch counter
    always_comb begin
        ifid_d        = ifid_q;
        fetch_count_d = fetch_count_q;
        if (ifid_load) begin
            if (ifid_bubble) begin
                ifid_d = '{instr: NOP, pc_plus4: '0, valid: 1'b0};
            end else begin
                ifid_d.instr    = out_of_range ? NOP : bus.Instruction;
                ifid_d.pc_plus4 = pc_plus4;
                ifid_d.valid    = ~out_of_range;
                if (!out_of_range)
                    fetch_count_d = fetch_count_q + XLEN'(1);
            end
        end
    end

    // PC, IF/ID and counter registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q          <= RESET_PC & ~XLEN'(3);
            ifid_q        <= '{instr: NOP, pc_plus4: '0, valid: 1'b0};
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            ifid_q        <= ifid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.ReadAddress      = pc_q;
    assign bus.IFID_Instruction = ifid_q.instr;
    assign bus.IFID_PCPlus4     = ifid_q.pc_plus4;
    assign bus.IFID_Valid       = ifid_q.valid;
    assign bus.JumpTaken        = jump_taken;
    assign bus.OutOfRange       = out_of_range;
    assign bus.FetchCount       = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed test-plan steps
// plus randomized control against a behavioural fetch model.
module tb_instruction_fetch_stage;

    localparam int MEM_WORDS = 30;
    localparam logic [31:0] LIMIT = 32'(4 * MEM_WORDS);

    logic Clk = 1'b0;
    logic Reset;

    instruction_fetch_stage_if bus ();

    instruction_fetch_stage #(
        .MEM_WORDS (MEM_WORDS),
        .RESET_PC  (32'h0000_0000),
        .NOP       (32'h0000_0000)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [0:31];

    assign bus.Instruction = (bus.ReadAddress < LIMIT)
                           ? mem[bus.ReadAddress[6:2]]
                           : (32'hBAD0_0000 ^ bus.ReadAddress);

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model of the stage state
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid, m_pc4_known;
    logic        chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    function automatic logic m_jump();
        return m_valid && (m_instr[31:26] == 6'b000010)
            && !bus.Stall;
    endfunction

    task automatic model_step();
        logic [31:0] tgt;
        if (Reset) begin
            m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
            m_cnt = 0; m_pc4_known = 1;
        end else if (bus.BranchTaken) begin
            m_pc = {bus.BranchTarget[31:2], 2'b00};
            m_instr = 0; m_valid = 0; m_pc4_known = 0;
        end else if (bus.Stall) begin
            // everything holds
        end else if (m_jump()) begin
            tgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
            m_pc = tgt;
            m_instr = 0; m_valid = 0; m_pc4_known = 0;
        end else begin
            if (m_pc < LIMIT) begin
                m_instr = mem[m_pc / 4];
                m_valid = 1;
                m_cnt = m_cnt + 1;
                m_pc4 = m_pc + 4;
                m_pc4_known = 1;
            end else begin
                m_instr = 0;
                m_valid = 0;
                m_pc4_known = 0;
            end
            m_pc = m_pc + 4;
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge Clk) begin
        if (chk_en) begin
            check("ReadAddress", bus.ReadAddress, m_pc);
            check("IFID_Instruction", bus.IFID_Instruction, m_instr);
            check("IFID_Valid", 32'(bus.IFID_Valid), 32'(m_valid));
            if (m_pc4_known)
                check("IFID_PCPlus4", bus.IFID_PCPlus4, m_pc4);
            check("JumpTaken", 32'(bus.JumpTaken), 32'(m_jump()));
            check("OutOfRange", 32'(bus.OutOfRange),
                  32'(m_pc >= LIMIT));
            check("FetchCount", bus.FetchCount, m_cnt);
        end
    end

    task automatic drive(input logic r, input logic s, input logic b,
                         input logic [31:0] t);
        Reset = r;
        bus.Stall = s;
        bus.BranchTaken = b;
        bus.BranchTarget = t;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        chk_en = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            logic [31:0] w;
            if ($urandom_range(0, 5) == 0) begin
                w = {6'b000010, 21'd0, 5'($urandom_range(0, 31))};
            end else begin
                w = $urandom;
                if (w[31:26] == 6'b000010) w[31:26] = 6'b100011;
            end
            mem[i] = w;
        end
        mem[0]  = 32'h2008_0020;
        mem[1]  = 32'h2009_0027;
        mem[2]  = 32'h0109_8024;
        mem[3]  = 32'h0109_8025;
        mem[17] = 32'h0800_000E;
        mem[20] = 32'h0800_001F;

        drive(1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0); #1;
        check("rst_pc", bus.ReadAddress, 32'h0);
        check("rst_valid", 32'(bus.IFID_Valid), 32'h0);
        check("rst_cnt", bus.FetchCount, 32'h0);
        check("rst_pc4", bus.IFID_PCPlus4, 32'h0);

        tick(); #1;
        check("run_pc1", bus.ReadAddress, 32'h4);
        check("run_ins1", bus.IFID_Instruction, 32'h2008_0020);
        check("run_pc4_1", bus.IFID_PCPlus4, 32'h4);
        tick(); #1;
        check("run_pc2", bus.ReadAddress, 32'h8);
        check("run_ins2", bus.IFID_Instruction, 32'h2009_0027);
        check("run_pc4_2", bus.IFID_PCPlus4, 32'h8);

        drive(0, 1, 0, 0);
        tick(); tick(); #1;
        check("stall_pc", bus.ReadAddress, 32'h8);
        check("stall_ins", bus.IFID_Instruction, 32'h2009_0027);
        drive(0, 0, 0, 0);
        tick(); #1;
        check("release_pc", bus.ReadAddress, 32'hC);
        check("release_cnt", bus.FetchCount, 32'd3);

        drive(0, 0, 1, 32'd68);
        tick();
        drive(0, 0, 0, 0); #1;
        check("br68_pc", bus.ReadAddress, 32'd68);
        tick();
        drive(0, 1, 0, 0); #1;
        check("jmp_deferred", 32'(bus.JumpTaken), 32'h0);
        tick();
        drive(0, 0, 0, 0); #1;
        check("jmp_held_pc", bus.ReadAddress, 32'd72);
        check("jmp_taken", 32'(bus.JumpTaken), 32'h1);
        tick(); #1;
        check("jmp_pc", bus.ReadAddress, 32'h38);
        check("jmp_bubble", 32'(bus.IFID_Valid), 32'h0);
        tick(); #1;
        check("jmp_target_ins", bus.IFID_Instruction, mem[14]);
        check("jmp_target_valid", 32'(bus.IFID_Valid), 32'h1);

        drive(0, 0, 1, 32'h50);
        tick();
        drive(0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 32'h4B); #1;
        check("br_vs_jmp_jt", 32'(bus.JumpTaken), 32'h1);
        tick();
        drive(0, 0, 0, 0); #1;
        check("br_vs_jmp_pc", bus.ReadAddress, 32'h48);
        check("br_vs_jmp_bub", 32'(bus.IFID_Valid), 32'h0);

        drive(0, 0, 1, 32'h50);
        tick();
        drive(0, 0, 0, 0);
        tick(); tick(); #1;
        check("oor_pc", bus.ReadAddress, 32'h7C);
        check("oor_flag", 32'(bus.OutOfRange), 32'h1);
        check("oor_cnt0", bus.FetchCount, 32'd7);
        tick(); tick(); #1;
        check("oor_valid", 32'(bus.IFID_Valid), 32'h0);
        check("oor_ins", bus.IFID_Instruction, 32'h0);
        check("oor_cnt", bus.FetchCount, 32'd7);
        drive(0, 0, 1, 32'h0);
        tick();
        drive(0, 0, 0, 0);
        tick(); #1;
        check("resume_ins", bus.IFID_Instruction, 32'h2008_0020);
        check("resume_cnt", bus.FetchCount, 32'd8);

        drive(1, 1, 1, 32'h40);
        tick();
        drive(0, 0, 0, 0); #1;
        check("rst_mid_pc", bus.ReadAddress, 32'h0);
        check("rst_mid_valid", 32'(bus.IFID_Valid), 32'h0);
        check("rst_mid_cnt", bus.FetchCount, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? $urandom
                                            : $urandom_range(0, 140);
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, t);
            tick();
        end

        @(negedge Clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
